// File: rtl/multi_port_sync_fifo.sv
// Multi-lane synchronous FIFO: PushPorts enqueue lanes and PopPorts dequeue lanes per cycle,
// arbitrary Depth with modulo pointer wrap, occupancy count, almost-full flag and single-cycle flush.
module multi_port_sync_fifo #(
  parameter int Depth           = 8,
  parameter int WordWidth       = 64,
  parameter int PushPorts       = 2,
  parameter int PopPorts        = 2,
  parameter int AlmostFullLevel = Depth - 2
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [PushPorts-1:0]            push_valid_i,
  input  logic [PushPorts*WordWidth-1:0]  push_payload_i,
  output logic [PushPorts-1:0]            push_ready_o,
  output logic [PopPorts-1:0]             pop_valid_o,
  output logic [PopPorts*WordWidth-1:0]   pop_payload_o,
  input  logic [PopPorts-1:0]             pop_ready_i,
  input  logic                            flush_i,
  output logic [$clog2(Depth+1)-1:0]      count_o,
  output logic                            empty_o,
  output logic                            full_o,
  output logic                            almost_full_o
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = $clog2(Depth + 1);

  // Handshake: a lane transfers on a cycle where its valid and ready are both high at the
  // rising edge. Ready (push) and valid (pop) depend only on registered state, and the
  // active lanes of push_valid_i / pop_ready_i must be contiguous from lane 0.

  logic [WordWidth-1:0] mem [Depth];
  logic [PtrW-1:0]      head_ptr, tail_ptr;
  logic [CntW-1:0]      count_q, count_d;
  logic [CntW-1:0]      n_push, n_pop, free_slots;
  logic [PtrW-1:0]      wr_idx [PushPorts];
  logic [PtrW-1:0]      rd_idx [PopPorts];

  function automatic logic [PtrW-1:0] wrap_add(input logic [PtrW-1:0] ptr,
                                               input logic [CntW-1:0] n);
    logic [CntW:0] sum;
    sum = (CntW+1)'(ptr) + (CntW+1)'(n);
    if (sum >= (CntW+1)'(Depth)) sum = sum - (CntW+1)'(Depth);
    return PtrW'(sum);
  endfunction

  assign free_slots = CntW'(Depth) - count_q;

  for (genvar k = 0; k < PushPorts; k++) begin : g_push
    assign push_ready_o[k] = free_slots > CntW'(k);
    assign wr_idx[k]       = wrap_add(tail_ptr, CntW'(k));
  end

  for (genvar k = 0; k < PopPorts; k++) begin : g_pop
    assign pop_valid_o[k]                          = count_q > CntW'(k);
    assign rd_idx[k]                               = wrap_add(head_ptr, CntW'(k));
    assign pop_payload_o[k*WordWidth +: WordWidth] = mem[rd_idx[k]];
  end

  always_comb begin
    n_push = '0;
    for (int k = 0; k < PushPorts; k++)
      if (push_valid_i[k] && push_ready_o[k]) n_push = n_push + CntW'(1);
  end

  always_comb begin
    n_pop = '0;
    for (int k = 0; k < PopPorts; k++)
      if (pop_valid_o[k] && pop_ready_i[k]) n_pop = n_pop + CntW'(1);
  end

  assign count_d = count_q + n_push - n_pop;

  always_ff @(posedge clk) begin
    if (!rstn || flush_i) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count_q  <= '0;
    end else begin
      head_ptr <= wrap_add(head_ptr, n_pop);
      tail_ptr <= wrap_add(tail_ptr, n_push);
      count_q  <= count_d;
    end
  end

  // Payload storage has no reset; writes are suppressed during reset and flush.
  always_ff @(posedge clk) begin
    if (rstn && !flush_i) begin
      for (int k = 0; k < PushPorts; k++)
        if (push_valid_i[k] && push_ready_o[k])
          mem[wr_idx[k]] <= push_payload_i[k*WordWidth +: WordWidth];
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      assert ((push_valid_i & (push_valid_i + PushPorts'(1))) == '0);
      assert ((pop_ready_i & (pop_ready_i + PopPorts'(1))) == '0);
    end
  end

  assign count_o       = count_q;
  assign empty_o       = (count_q == '0);
  assign full_o        = (count_q == CntW'(Depth));
  assign almost_full_o = (count_q >= CntW'(AlmostFullLevel));

endmodule

// File: doc/multi_port_sync_fifo.md
Name: multi_port_sync_fifo

Overview:
Parametrised synchronous FIFO with PushPorts enqueue lanes and PopPorts dequeue lanes per cycle. It is the superscalar successor to the single-port sync FIFO, used between rename/dispatch and issue queues and in the LSU/fetch buffers. It adds per-lane valid/ready handshakes, an occupancy count, an almost-full flag and support for any Depth (not just powers of 2), and it keeps single-cycle flush.

Parameters:
Depth, 8, number of entries; any integer >= 2
WordWidth, 64, payload bits per entry
PushPorts, 2, enqueue lanes; 1..Depth
PopPorts, 2, dequeue lanes; 1..Depth
AlmostFullLevel, Depth-2, almost_full_o asserts when count >= this value; 1..Depth

Ports:
clk  input  1  clock; all state updates on the rising edge
rstn  input  1  synchronous active-low reset
push_valid_i  input  PushPorts  lane k has data to enqueue
push_payload_i  input  PushPorts*WordWidth  lane k payload in bits [k*WordWidth +: WordWidth]
push_ready_o  output  PushPorts  lane k can be accepted this cycle
pop_valid_o  output  PopPorts  lane k holds a valid entry
pop_payload_o  output  PopPorts*WordWidth  lane k = k-th oldest entry
pop_ready_i  input  PopPorts  consumer takes lane k
flush_i  input  1  discard all contents
count_o  output  $clog2(Depth+1)  registered occupancy
empty_o  output  1  count_o == 0
full_o  output  1  count_o == Depth
almost_full_o  output  1  count_o >= AlmostFullLevel

Behaviour:
- State: head_ptr and tail_ptr, each $clog2(Depth) bits, plus count_q. Pointers wrap modulo Depth: (ptr + n) >= Depth subtracts Depth. No flag bit is kept; full/empty come only from count_q.
- Reset (rstn=0 at a rising edge): head_ptr, tail_ptr and count_q go to 0. Payload storage is not reset. After reset: push_ready_o = all ones if Depth >= PushPorts, pop_valid_o = 0, count_o = 0, empty_o = 1, full_o = 0, almost_full_o = 0.
- Lane contiguity: push_valid_i and pop_ready_i must be thermometer-coded from lane 0 (for example 0b011 is legal, 0b101 is illegal). An illegal pattern fires a simulation assertion; RTL behaviour is then undefined.
- push_ready_o[k] = (Depth - count_q) > k. It uses the registered count only. Slots freed by a same-cycle pop are not credited.
- n_push = popcount(push_valid_i & push_ready_o). Lane k is written to entry (tail_ptr + k) mod Depth, and tail_ptr advances by n_push.
- pop_valid_o[k] = count_q > k. pop_payload_o lane k = entry (head_ptr + k) mod Depth.
- n_pop = popcount(pop_valid_o & pop_ready_i), and head_ptr advances by n_pop. Asserting pop_ready_i on an invalid lane has no effect.
- count_q next = count_q + n_push - n_pop.
- Latency: a pushed entry becomes visible on pop_valid_o the cycle after acceptance. There is no push-to-pop bypass. Outputs are functions of registered state only (no comb path from push_*_i or pop_ready_i to outputs).
- Simultaneous push and pop are both honoured. At full, push_ready_o = 0 even if a pop occurs in the same cycle.
- flush_i=1 has priority over push and pop. Next cycle head_ptr, tail_ptr and count_q are 0, pushes in the flush cycle are dropped, and no entry counts as popped. Ready/valid outputs during the flush cycle still reflect pre-flush state.
- Reset asserted mid-operation overrides flush, push and pop.

Test Plan:
- Reset, then Depth=8, PushPorts=2: push_valid_i=2'b11 for 4 cycles -> count_o 2,4,6,8; full_o=1 and push_ready_o=2'b00 in cycle 5. almost_full_o rises when count_o reaches 6.
- Depth=6, PushPorts=PopPorts=2: push 0xA..0xF, pop 4, push 0x10,0x11,0x12,0x13 -> pop order 0xE,0xF,0x10,0x11,0x12,0x13. This checks wrap past entry 5 to entry 0.
- count=7 of 8, push_valid_i=2'b11 -> push_ready_o=2'b01. Only lane 0 is written; count_o=8 next cycle.
- Full FIFO, pop_ready_i=2'b01 and push_valid_i=2'b01 in the same cycle -> push_ready_o=0, pop accepted, count_o=7 next cycle.
- count=5, flush_i=1 together with push_valid_i=2'b11 -> next cycle count_o=0, empty_o=1, pop_valid_o=0; the two pushed words are never popped.
- count=3, pop_ready_i=2'b11 -> pop_payload_o lanes show oldest and second-oldest; count_o=1 next cycle, and the next pop_payload_o lane 0 = third-oldest entry.
